// File: rtl/updown_pulse_pkg.sv
// updown_pulse_pkg: shared state type and phase-timer sizing for updown_pulse_gen
package updown_pulse_pkg;
    typedef enum logic [1:0] {IDLE, LOW, GAP, FIN} state_t;

    function automatic int timer_w(int pulse_w, int gap_w);
        int m = pulse_w > gap_w ? pulse_w : gap_w;
        return m > 1 ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/updown_pulse_gen_phase_timer.sv
// phase_timer: loadable down-counter that flags terminal count at zero
module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - 1'b1;

    assign tc = count == '0;
endmodule

// File: rtl/updown_pulse_gen.sv
// updown_pulse_gen: paced active-low UP/DOWN pulse trains for a 74193-style counter,
// with carry/borrow wrap detection and optional stop on wrap
module updown_pulse_gen
    import updown_pulse_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk_drv,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_count,
    input  logic             stop_on_wrap,
    output logic             up,
    output logic             down,
    input  logic             co_n,
    input  logic             bo_n,
    output logic             done,
    output logic             wrap,
    output logic [CNT_W-1:0] remain
);
    localparam int TW = timer_w(PULSE_W, GAP_W);

    state_t state, state_next;
    logic dir, dir_next, stop, stop_next, acc, acc_next, load, tc, accept;
    logic [TW-1:0] load_val;
    logic [CNT_W-1:0] remain_next;

    phase_timer #(.W(TW)) u_timer (
        .clk(clk_drv), .rst(reset), .load(load), .load_val(load_val), .tc(tc)
    );

    assign req_ready = state == IDLE;
    assign accept    = req_ready && req_valid;
    assign dir_next  = accept ? req_dir : dir;
    assign stop_next = accept ? stop_on_wrap : stop;

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        load_val    = TW'(PULSE_W - 1);
        remain_next = remain;
        // carry/borrow is only meaningful on the last low cycle of a pulse
        acc_next    = acc | (state == LOW && tc && !(dir ? co_n : bo_n));
        case (state)
            IDLE: if (req_valid) begin
                acc_next    = 1'b0;
                state_next  = req_count == '0 ? FIN : LOW;
                load        = req_count != '0;
                remain_next = req_count == '0 ? '0 : req_count - 1'b1;
            end
            LOW: if (tc) begin
                state_next = GAP;
                load       = 1'b1;
                load_val   = TW'(GAP_W - 1);
            end
            GAP: if (tc) begin
                if (remain == '0 || (stop && acc)) state_next = FIN;
                else begin
                    state_next  = LOW;
                    load        = 1'b1;
                    remain_next = remain - 1'b1;
                end
            end
            FIN: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_drv or posedge reset)
        if (reset) begin
            state  <= IDLE;
            dir    <= 1'b1;
            stop   <= 1'b0;
            acc    <= 1'b0;
            remain <= '0;
            up     <= 1'b1;
            down   <= 1'b1;
            done   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            state  <= state_next;
            dir    <= dir_next;
            stop   <= stop_next;
            acc    <= acc_next;
            remain <= remain_next;
            up     <= !(state_next == LOW && dir_next);
            down   <= !(state_next == LOW && !dir_next);
            done   <= state_next == FIN;
            wrap   <= state_next == FIN && acc_next;
        end
endmodule

// File: tb/tb_updown_pulse_gen.sv
// tb_updown_pulse_gen: randomized and directed requests against a schedule-level
// reference model, driving a behavioural 74193-style counter
module tb_updown_pulse_gen;
    localparam int P = 4, G = 4, PER = P + G;

    logic clk = 0, reset = 1;
    logic req_valid = 0, req_dir = 0, stop_on_wrap = 0;
    logic [7:0] req_count = 0;
    logic req_ready, up, down, done, wrap, co_n, bo_n;
    logic [7:0] remain;

    logic [3:0] cnt = 0, ld_val = 0;
    logic ld = 0, up_q = 1, down_q = 1;

    int vectors = 0, miscompares = 0;
    int scen = 0, ncyc = 0, acc_n = 0, pdone = 0;
    bit busy = 0, prev_rdy = 1, m_dir = 0, m_wrap = 0;
    int m_n = 0, issued = 0, last_rem = 0;

    updown_pulse_gen #(.PULSE_W(P), .GAP_W(G), .CNT_W(8)) dut (
        .clk_drv(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_dir(req_dir), .req_count(req_count), .stop_on_wrap(stop_on_wrap),
        .up(up), .down(down), .co_n(co_n), .bo_n(bo_n),
        .done(done), .wrap(wrap), .remain(remain)
    );

    always #5 clk = ~clk;

    // counter clocks on rising edges of UP/DOWN
    always @(up or down or reset or ld) begin
        if (reset) cnt = 0;
        else if (ld) cnt = ld_val;
        else begin
            if (up && !up_q) cnt = cnt + 1;
            if (down && !down_q) cnt = cnt - 1;
        end
        up_q = up;
        down_q = down;
    end
    assign co_n = !(cnt == 4'd15 && !up);
    assign bo_n = !(cnt == 4'd0 && !down);

    task automatic chk(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, ncyc, act, exp_v);
        end
    endtask

    always @(negedge clk or posedge reset) begin : model
        int o, c, dly;
        bit e_up, e_dn, e_done, e_rdy, low;
        int e_rem;
        if (clk) begin
            #1;
            chk("async_up", up, 1);
            chk("async_down", down, 1);
            chk("async_ready", req_ready, 1);
        end else begin
            if (reset) begin
                busy = 0; last_rem = 0; prev_rdy = 1;
                chk("rst_up", up, 1); chk("rst_down", down, 1); chk("rst_ready", req_ready, 1);
                chk("rst_done", done, 0); chk("rst_wrap", wrap, 0); chk("rst_remain", remain, 0);
            end else begin
                if (!busy && prev_rdy && req_valid) begin
                    busy = 1; acc_n = ncyc; m_dir = req_dir; m_n = req_count;
                    c = cnt; issued = 0; m_wrap = 0;
                    for (int i = 0; i < m_n; i++) begin
                        if (m_dir ? c == 15 : c == 0) m_wrap = 1;
                        c = (m_dir ? c + 1 : c + 15) % 16;
                        issued++;
                        if (stop_on_wrap && m_wrap) break;
                    end
                end
                e_up = 1; e_dn = 1; e_done = 0; e_rdy = !busy; e_rem = last_rem;
                if (busy) begin
                    o = ncyc - acc_n;
                    if (o < issued * PER) begin
                        low = (o % PER) < P;
                        e_up = !(low && m_dir);
                        e_dn = !(low && !m_dir);
                        e_rem = m_n - 1 - o / PER;
                    end else begin
                        e_done = 1;
                        e_rem = m_n - issued;
                    end
                end
                chk("up", up, e_up); chk("down", down, e_dn); chk("done", done, e_done);
                chk("ready", req_ready, e_rdy); chk("remain", remain, e_rem);
                if (e_done) begin
                    chk("wrap", wrap, m_wrap);
                    busy = 0;
                    last_rem = e_rem;
                end
                if (done) begin
                    dly = ncyc - acc_n + 1;
                    case (scen)
                        1: begin chk("s1_done_cycle", dly, 41); chk("s1_count", cnt, 8); chk("s1_wrap", wrap, 0); end
                        2: begin chk("s2_done_cycle", dly, 33); chk("s2_count", cnt, 2); chk("s2_wrap", wrap, 1); end
                        3: begin chk("s3_done_cycle", dly, 17); chk("s3_count", cnt, 0); chk("s3_wrap", wrap, 1); chk("s3_remain", remain, 2); end
                        4: begin chk("s4_done_cycle", dly, 25); chk("s4_count", cnt, 14); chk("s4_wrap", wrap, 1); end
                        5: begin chk("s5_done_cycle", dly, 1); chk("s5_wrap", wrap, 0); chk("s5_remain", remain, 0); end
                        6: begin chk("s6_done_cycle", dly, 9); chk("s6_spacing", acc_n - pdone, 2); chk("s6_count", cnt, 15); end
                        7: begin chk("s7_done_cycle", dly, 2041); chk("s7_count", cnt, 14); chk("s7_remain", remain, 0); end
                        default: ;
                    endcase
                    pdone = ncyc;
                end
                prev_rdy = e_rdy;
            end
            ncyc++;
        end
    end

    task automatic timeout(input string nm);
        $display("FAIL %s: wait bound expired", nm);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    endtask

    task automatic preload(input int v);
        @(negedge clk); #1;
        ld_val = 4'(v); ld = 1;
        #1 ld = 0;
    endtask

    task automatic run(input bit d, input int n, input bit s, input bit busy_v);
        int t;
        @(negedge clk); #1;
        req_valid = 1; req_dir = d; req_count = 8'(n); stop_on_wrap = s;
        t = 0;
        while (!req_ready) begin
            @(negedge clk); #1;
            t++;
            if (t > 100) timeout("ready_wait");
        end
        @(negedge clk);
        t = 0;
        while (!done) begin
            #1;
            req_valid = busy_v; req_dir = 1'($urandom); req_count = 8'($urandom); stop_on_wrap = 1'($urandom);
            @(negedge clk);
            t++;
            if (t > 5000) timeout("done_wait");
        end
        #1 req_valid = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 0;
        repeat (100) @(negedge clk);
        preload(3);  scen = 1; run(1, 5, 0, 0);
        preload(14); scen = 2; run(1, 4, 0, 1);
        preload(14); scen = 3; run(1, 4, 1, 1);
        preload(1);  scen = 4; run(0, 3, 0, 0);
        scen = 5; run(1, 0, 0, 1);
        scen = 6; run(1, 1, 0, 0);
        scen = 7; run(1, 255, 0, 1);
        scen = 0;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) preload(int'($urandom_range(0, 15)));
            run(1'($urandom), int'($urandom_range(0, 12)), 1'($urandom), 1'($urandom));
        end
        @(negedge clk); #1;
        req_valid = 1; req_dir = 1; req_count = 5; stop_on_wrap = 0;
        @(negedge clk); #1 req_valid = 0;
        repeat (17) @(negedge clk);
        @(posedge clk); #1 reset = 1;
        repeat (3) @(negedge clk);
        #1 reset = 0;
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
